// File: rtl/lieat_exu_lsu_oq_if.sv
// lieat_exu_lsu_oq_if: handshake/bus bundle for the EXU load/store unit
//  flush_req            pipeline flush
//  lsu_i_*              issue side: valid/ready, pc/imm/src1/src2, load/store, size, usign, rd, rdwen
//  lsu_req_*            bus request: valid/ready, ren/wen, addr, wdata, flag {usign,size}
//  lsu_rsp_*            bus response: valid/ready, rdata
//  lsu_o_*              writeback: valid/ready, pc, data, rd, wen, misalign
//  mmio_*               local MMIO side port: wen, addr (16-bit offset), wdata, rdata
//  slave = LSU view, master = environment view
interface lieat_exu_lsu_oq_if #(
  parameter int XLEN    = 32,
  parameter int REG_IDX = 5
);
  logic               flush_req;
  logic               lsu_i_valid, lsu_i_ready;
  logic [XLEN-1:0]    lsu_i_pc, lsu_i_imm, lsu_i_src1, lsu_i_src2;
  logic               lsu_i_load, lsu_i_store;
  logic [1:0]         lsu_i_size;
  logic               lsu_i_usign;
  logic [REG_IDX-1:0] lsu_i_rd;
  logic               lsu_i_rdwen;
  logic               lsu_req_valid, lsu_req_ready, lsu_req_ren, lsu_req_wen;
  logic [XLEN-1:0]    lsu_req_addr, lsu_req_wdata;
  logic [2:0]         lsu_req_flag;
  logic               lsu_rsp_valid, lsu_rsp_ready;
  logic [XLEN-1:0]    lsu_rsp_rdata;
  logic               lsu_o_valid, lsu_o_ready;
  logic [XLEN-1:0]    lsu_o_pc, lsu_o_data;
  logic [REG_IDX-1:0] lsu_o_rd;
  logic               lsu_o_wen, lsu_o_misalign;
  logic               mmio_wen;
  logic [15:0]        mmio_addr;
  logic [XLEN-1:0]    mmio_wdata, mmio_rdata;
  modport slave (
    input  flush_req, lsu_i_valid, lsu_i_pc, lsu_i_imm, lsu_i_src1, lsu_i_src2, lsu_i_load, lsu_i_store,
           lsu_i_size, lsu_i_usign, lsu_i_rd, lsu_i_rdwen, lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
           lsu_o_ready, mmio_rdata,
    output lsu_i_ready, lsu_req_valid, lsu_req_ren, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_flag,
           lsu_rsp_ready, lsu_o_valid, lsu_o_pc, lsu_o_data, lsu_o_rd, lsu_o_wen, lsu_o_misalign,
           mmio_wen, mmio_addr, mmio_wdata
  );
  modport master (
    output flush_req, lsu_i_valid, lsu_i_pc, lsu_i_imm, lsu_i_src1, lsu_i_src2, lsu_i_load, lsu_i_store,
           lsu_i_size, lsu_i_usign, lsu_i_rd, lsu_i_rdwen, lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
           lsu_o_ready, mmio_rdata,
    input  lsu_i_ready, lsu_req_valid, lsu_req_ren, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_flag,
           lsu_rsp_ready, lsu_o_valid, lsu_o_pc, lsu_o_data, lsu_o_rd, lsu_o_wen, lsu_o_misalign,
           mmio_wen, mmio_addr, mmio_wdata
  );
endinterface

// File: rtl/lieat_exu_lsu_oq.sv
// lieat_exu_lsu_oq: EXU load/store unit with in-order outstanding bus tracking and local MMIO side port
//  clock, reset (async, active-low); io: lieat_exu_lsu_oq_if.slave (issue, bus req/rsp, writeback, MMIO)
//  Optional macro LIEAT_LSU_MISALIGN_EN: misaligned H/W ops complete locally with lsu_o_misalign=1
module lieat_exu_lsu_oq #(
  parameter int              XLEN      = 32,
  parameter int              REG_IDX   = 5,
  parameter int              OSTD      = 2,
  parameter logic [XLEN-1:0] MMIO_BASE = 32'h0200_0000,
  parameter logic [XLEN-1:0] MMIO_MASK = 32'hFFFF_0000
) (
  input logic               clock,
  input logic               reset,
  lieat_exu_lsu_oq_if.slave io
);
  localparam int AW = OSTD > 1 ? $clog2(OSTD) : 1;
  localparam int CW = $clog2(OSTD + 1);
  logic               s_valid, s_load, s_store, s_usign, s_rdwen;
  logic [1:0]         s_size;
  logic [XLEN-1:0]    s_pc, s_addr, s_wdata;
  logic [REG_IDX-1:0] s_rd;
  logic [XLEN-1:0]    f_pc [OSTD];
  logic [REG_IDX-1:0] f_rd [OSTD];
  logic [OSTD-1:0]    f_wen, f_drop;
  logic [AW-1:0]      wptr, rptr;
  logic [CW-1:0]      cnt;
  logic mmio_hit, misal, empty, full, req_hs, rsp_hs, bus_out, local_ok, local_hs, stage_leave, acc;
  assign mmio_hit = (s_addr & MMIO_MASK) == MMIO_BASE;
`ifdef LIEAT_LSU_MISALIGN_EN
  assign misal = (s_size == 2'd1 & s_addr[0]) | (s_size == 2'd2 & s_addr[1:0] != 2'd0);
`else
  assign misal = 1'b0;
`endif
  assign empty = cnt == '0;
  assign full  = cnt == CW'(OSTD);
  assign io.lsu_req_valid = s_valid & ~mmio_hit & ~misal & ~io.flush_req & ~full;
  assign io.lsu_req_ren   = s_load;
  assign io.lsu_req_wen   = s_store;
  assign io.lsu_req_addr  = s_addr;
  assign io.lsu_req_wdata = s_wdata;
  assign io.lsu_req_flag  = {s_usign, s_size};
  assign req_hs = io.lsu_req_valid & io.lsu_req_ready;
  // dropped heads are drained unconditionally; live heads follow writeback backpressure
  assign io.lsu_rsp_ready = ~empty & (f_drop[rptr] | io.lsu_o_ready);
  assign rsp_hs  = io.lsu_rsp_valid & io.lsu_rsp_ready;
  assign bus_out = io.lsu_rsp_valid & ~empty & ~f_drop[rptr];
  // local completion (MMIO or misalign) waits for an empty FIFO to keep program order
  assign local_ok = s_valid & empty & (mmio_hit | misal);
  assign io.lsu_o_valid    = ~io.flush_req & (bus_out | local_ok);
  assign io.lsu_o_pc       = bus_out ? f_pc[rptr] : s_pc;
  assign io.lsu_o_data     = bus_out ? io.lsu_rsp_rdata : misal ? s_addr : io.mmio_rdata;
  assign io.lsu_o_rd       = bus_out ? f_rd[rptr] : s_rd;
  assign io.lsu_o_wen      = bus_out ? f_wen[rptr] : s_rdwen & ~misal;
  assign io.lsu_o_misalign = ~bus_out & misal;
  assign local_hs    = local_ok & io.lsu_o_valid & io.lsu_o_ready;
  assign io.mmio_wen   = local_hs & ~misal & s_store;
  assign io.mmio_addr  = s_addr[15:0];
  assign io.mmio_wdata = s_wdata;
  assign stage_leave    = req_hs | local_hs | io.flush_req;
  assign io.lsu_i_ready = ~s_valid | stage_leave;
  assign acc = io.lsu_i_valid & io.lsu_i_ready;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_valid <= 1'b0;
      cnt     <= '0;
      wptr    <= '0;
      rptr    <= '0;
      f_drop  <= '0;
    end else begin
      s_valid <= acc | (s_valid & ~stage_leave);
      cnt     <= cnt + CW'(req_hs) - CW'(rsp_hs);
      if (req_hs) wptr <= wptr == AW'(OSTD - 1) ? '0 : wptr + 1'b1;
      if (rsp_hs) rptr <= rptr == AW'(OSTD - 1) ? '0 : rptr + 1'b1;
      f_drop <= io.flush_req ? '1 : f_drop & ~(OSTD'(req_hs) << wptr);
    end
  end
  always_ff @(posedge clock) begin
    if (acc) begin
      s_pc    <= io.lsu_i_pc;
      s_addr  <= io.lsu_i_src1 + io.lsu_i_imm;
      s_wdata <= io.lsu_i_src2;
      s_load  <= io.lsu_i_load;
      s_store <= io.lsu_i_store;
      s_size  <= io.lsu_i_size;
      s_usign <= io.lsu_i_usign;
      s_rd    <= io.lsu_i_rd;
      s_rdwen <= io.lsu_i_rdwen;
    end
    if (req_hs) begin
      f_pc[wptr]  <= s_pc;
      f_rd[wptr]  <= s_rd;
      f_wen[wptr] <= s_rdwen;
    end
  end
endmodule

// File: tb/tb_lieat_exu_lsu_oq.sv
// tb_lieat_exu_lsu_oq: scoreboard bench for lieat_exu_lsu_oq with a 3-cycle in-order bus model
module tb_lieat_exu_lsu_oq;
  typedef logic [70:0] wb_t;
  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, failures = 0;
  int cyc = 0, mmio_cnt = 0, drop_seen = 0;
  logic drop_win = 1'b0;
  logic [15:0] mm_addr_exp = 16'h4000;
  logic [31:0] mm_wdata_exp = 32'hDEAD_BEEF;
  logic [31:0] last_addr = '0;
  logic [2:0]  last_flag = '0;
  wb_t   sb[$];
  pend_t pend[$];
  int    req_log[$];
  int    rsp_log[$];
  lieat_exu_lsu_oq_if #(.XLEN(32), .REG_IDX(5)) bus ();
  lieat_exu_lsu_oq #(.OSTD(2)) dut (.clock(clock), .reset(rst_n), .io(bus));
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask
  // bus model: handshakes observed mid-cycle, responses presented just after the edge
  always @(negedge clock) begin
    if (!rst_n) begin
      pend.delete();
      req_log.delete();
      rsp_log.delete();
    end else begin
      if (bus.lsu_rsp_valid && bus.lsu_rsp_ready && pend.size() > 0) begin
        pend.delete(0);
        rsp_log.push_back(cyc);
      end
      if (bus.lsu_req_valid && bus.lsu_req_ready) begin
        pend.push_back('{cyc + 3, bus.lsu_req_addr});
        req_log.push_back(cyc);
        last_addr = bus.lsu_req_addr;
        last_flag = bus.lsu_req_flag;
      end
    end
  end
  always @(posedge clock) begin
    cyc++;
    #1;
    bus.lsu_rsp_valid = rst_n && pend.size() > 0 && pend[0].due <= cyc;
    bus.lsu_rsp_rdata = pend.size() > 0 ? pend[0].addr + 32'h100 : 32'h0;
  end
  // monitor
  always @(negedge clock) begin
    if (rst_n) begin
      if (bus.lsu_o_valid && bus.lsu_o_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected got pc=%0h data=%0h", bus.lsu_o_pc, bus.lsu_o_data);
        end else begin
          chk("wb", {bus.lsu_o_pc, bus.lsu_o_data, bus.lsu_o_rd, bus.lsu_o_wen, bus.lsu_o_misalign}, sb[0]);
          sb.delete(0);
        end
      end
      if (drop_win && bus.lsu_rsp_valid) begin
        drop_seen++;
        chk("drop_rsp_ready", bus.lsu_rsp_ready, 1);
        chk("drop_o_valid", bus.lsu_o_valid, 0);
      end
      if (bus.mmio_wen) begin
        mmio_cnt++;
        chk("mmio_addr", bus.mmio_addr, mm_addr_exp);
        chk("mmio_wdata", bus.mmio_wdata, mm_wdata_exp);
      end
    end
  end
  task automatic expect_wb(input logic [31:0] pc, data, input logic [4:0] rd, input logic wen, mis);
    sb.push_back({pc, data, rd, wen, mis});
  endtask
  task automatic issue(input logic [31:0] pc, src1, imm, src2, input logic ld, st,
                       input logic [1:0] sz, input logic us, input logic [4:0] rd, input logic wen);
    bus.lsu_i_pc = pc; bus.lsu_i_src1 = src1; bus.lsu_i_imm = imm; bus.lsu_i_src2 = src2;
    bus.lsu_i_load = ld; bus.lsu_i_store = st; bus.lsu_i_size = sz; bus.lsu_i_usign = us;
    bus.lsu_i_rd = rd; bus.lsu_i_rdwen = wen; bus.lsu_i_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (bus.lsu_i_ready) break;
    end
    chk("issue_ready", bus.lsu_i_ready, 1);
    @(posedge clock); #1;
    bus.lsu_i_valid = 1'b0;
  endtask
  task automatic load(input logic [31:0] pc, addr, input logic [4:0] rd);
    issue(pc, addr, 32'h0, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, rd, 1'b1);
  endtask
  task automatic drain;
    for (int n = 0; n < 300 && sb.size() != 0; n++) @(posedge clock);
    #1;
    chk("drain", sb.size(), 0);
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    bus.lsu_i_valid = 1'b0; bus.flush_req = 1'b0; bus.lsu_o_ready = 1'b1; bus.lsu_req_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_valid", bus.lsu_req_valid, 0);
    chk("rst_o_valid", bus.lsu_o_valid, 0);
    chk("rst_mmio_wen", bus.mmio_wen, 0);
    chk("rst_i_ready", bus.lsu_i_ready, 1);
    rst_n = 1'b1;
    @(posedge clock); #1;
  endtask
  initial begin
    bus.flush_req = 1'b0; bus.lsu_i_valid = 1'b0; bus.lsu_req_ready = 1'b1; bus.lsu_o_ready = 1'b1;
    bus.mmio_rdata = 32'h1234_5678;
    bus.lsu_i_pc = '0; bus.lsu_i_imm = '0; bus.lsu_i_src1 = '0; bus.lsu_i_src2 = '0;
    bus.lsu_i_load = 1'b0; bus.lsu_i_store = 1'b0; bus.lsu_i_size = '0; bus.lsu_i_usign = 1'b0;
    bus.lsu_i_rd = '0; bus.lsu_i_rdwen = 1'b0;
    // back-to-back loads: third request must wait for the first response
    do_reset();
    expect_wb(32'h100, 32'h8000_0100, 5'd1, 1'b1, 1'b0);
    expect_wb(32'h104, 32'h8000_0104, 5'd2, 1'b1, 1'b0);
    expect_wb(32'h108, 32'h8000_0108, 5'd3, 1'b1, 1'b0);
    issue(32'h100, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd1, 1'b1);
    issue(32'h104, 32'h8000_0000, 32'h4, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd2, 1'b1);
    issue(32'h108, 32'h8000_0000, 32'h8, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd3, 1'b1);
    drain();
    chk("t1_third_req_after_rsp",
        req_log.size() == 3 && rsp_log.size() >= 1 && req_log[2] > rsp_log[0], 1);
    // flush with two loads outstanding: responses drained silently
    do_reset();
    load(32'h200, 32'h8000_0020, 5'd4);
    load(32'h204, 32'h8000_0024, 5'd5);
    for (int n = 0; n < 50 && req_log.size() < 2; n++) @(posedge clock);
    #1;
    chk("t2_reqs", req_log.size(), 2);
    drop_seen = 0;
    drop_win = 1'b1;
    bus.flush_req = 1'b1;
    @(posedge clock); #1;
    bus.flush_req = 1'b0;
    for (int n = 0; n < 50 && rsp_log.size() < 2; n++) @(posedge clock);
    #1;
    drop_win = 1'b0;
    chk("t2_rsps", rsp_log.size(), 2);
    chk("t2_drop_seen", drop_seen, 2);
    expect_wb(32'h208, 32'h8000_0130, 5'd6, 1'b1, 1'b0);
    load(32'h208, 32'h8000_0030, 5'd6);
    drain();
    // MMIO store under writeback backpressure
    do_reset();
    mmio_cnt = 0;
    bus.lsu_o_ready = 1'b0;
    expect_wb(32'h300, 32'h1234_5678, 5'd0, 1'b0, 1'b0);
    issue(32'h300, 32'h0200_0000, 32'h4000, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    chk("t3_no_strobe_backpressure", mmio_cnt, 0);
    bus.lsu_o_ready = 1'b1;
    drain();
    repeat (3) @(posedge clock);
    #1;
    chk("t3_strobe_count", mmio_cnt, 1);
    chk("t3_no_bus_req", req_log.size(), 0);
    // MMIO load ordered behind an outstanding bus load
    do_reset();
    expect_wb(32'h400, 32'h8000_0100, 5'd6, 1'b1, 1'b0);
    expect_wb(32'h404, 32'h1234_5678, 5'd7, 1'b1, 1'b0);
    load(32'h400, 32'h8000_0000, 5'd6);
    issue(32'h404, 32'h0200_B000, 32'hFF8, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd7, 1'b1);
    drain();
    chk("t4_one_bus_req", req_log.size(), 1);
    // halfword load to an odd address
    do_reset();
`ifdef LIEAT_LSU_MISALIGN_EN
    expect_wb(32'h500, 32'h8000_0003, 5'd3, 1'b0, 1'b1);
    issue(32'h500, 32'h8000_0001, 32'h2, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, 5'd3, 1'b1);
    drain();
    repeat (3) @(posedge clock);
    #1;
    chk("t5_no_bus_req", req_log.size(), 0);
`else
    expect_wb(32'h500, 32'h8000_0103, 5'd3, 1'b1, 1'b0);
    issue(32'h500, 32'h8000_0001, 32'h2, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, 5'd3, 1'b1);
    drain();
    chk("t5_req_addr", last_addr, 32'h8000_0003);
    chk("t5_req_flag", last_flag, 3'b001);
`endif
    // async reset with one load outstanding
    do_reset();
    load(32'h600, 32'h8000_0040, 5'd8);
    for (int n = 0; n < 50 && req_log.size() < 1; n++) @(posedge clock);
    #1;
    chk("t6_req", req_log.size(), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_req_valid_async", bus.lsu_req_valid, 0);
    chk("t6_o_valid_async", bus.lsu_o_valid, 0);
    chk("t6_mmio_wen_async", bus.mmio_wen, 0);
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    @(posedge clock); #1;
    expect_wb(32'h604, 32'h1234_5678, 5'd9, 1'b1, 1'b0);
    issue(32'h604, 32'h0200_0000, 32'h10, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd9, 1'b1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
